// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction ROM port, branch/stall controls from later
// stages, and the IF/ID register outputs toward decode.
//   master : the fetch stage (drives imem_addr and the IF/ID outputs)
//   slave  : the environment (ROM, branch unit, decode)
interface fetch_stage_if #(
  parameter int unsigned N = 64
);
  logic [5:0]   imem_addr;
  logic [31:0]  imem_q;
  logic         pc_src;
  logic [N-1:0] pc_branch;
  logic         stall;
  logic         if_valid;
  logic [31:0]  if_instr;
  logic [N-1:0] if_pc;
  logic         halted;
  logic [31:0]  fetch_count;

  modport master (
    output imem_addr, if_valid, if_instr, if_pc, halted, fetch_count,
    input  imem_q, pc_src, pc_branch, stall
  );

  modport slave (
    input  imem_addr, if_valid, if_instr, if_pc, halted, fetch_count,
    output imem_q, pc_src, pc_branch, stall
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage. Owns the PC, addresses a combinational-read
// instruction ROM, and captures the returned word into an IF/ID register.
// Handles decode stall, branch redirect (which also leaves HALT), halting
// on an all-zero word, and a saturating count of accepted fetches.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : fetch_stage_if.master (ROM address/data, pc_src, pc_branch,
//           stall, if_valid, if_instr, if_pc, halted, fetch_count)
module fetch_stage #(
  parameter int unsigned N = 64
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master bus
);

  localparam int unsigned IW = 32;
  localparam logic [IW-1:0] CNT_MAX = '1;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  pc_q, pc_d;
  logic          valid_q, valid_d;
  logic [IW-1:0] instr_q, instr_d;
  logic [N-1:0]  ifpc_q, ifpc_d;
  logic [IW-1:0] cnt_q, cnt_d;

  // A normal fetch happens only in RUN with no redirect, no stall and a
  // non-sentinel word on the ROM.
  logic fetch_ok;
  logic sentinel;

  always_comb begin
    sentinel = (bus.imem_q == '0);
    fetch_ok = (state_q == ST_RUN) && !bus.pc_src && !bus.stall && !sentinel;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: redirect always returns to RUN; the zero word halts.
  always_comb begin
    state_d = state_q;
    if (bus.pc_src) begin
      state_d = ST_RUN;
    end else if (state_q == ST_RUN && !bus.stall && sentinel) begin
      state_d = ST_HALT;
    end
  end

  // Datapath next values, priority redirect > halt/stall hold > fetch.
  always_comb begin
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    cnt_d   = cnt_q;
    if (bus.pc_src) begin
      pc_d    = bus.pc_branch;
      valid_d = 1'b0;
    end else if (state_q == ST_RUN && !bus.stall) begin
      if (sentinel) begin
        valid_d = 1'b0;
      end else begin
        instr_d = bus.imem_q;
        ifpc_d  = pc_q;
        valid_d = 1'b1;
        pc_d    = pc_q + N'(4);
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + IW'(1);
        end
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= '0;
      valid_q <= 1'b0;
      instr_q <= '0;
      ifpc_q  <= '0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output decode; the ROM aliases every 256 bytes so only pc[7:2] is used.
  always_comb begin
    bus.imem_addr   = pc_q[7:2];
    bus.halted      = (state_q == ST_HALT);
    bus.if_valid    = valid_q;
    bus.if_instr    = instr_q;
    bus.if_pc       = ifpc_q;
    bus.fetch_count = cnt_q;
  end

  logic unused_ok;
  always_comb unused_ok = fetch_ok;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam int unsigned N = 64;

  logic clk;
  logic reset;
  logic [31:0] rom [64];

  fetch_stage_if #(.N(N)) bus ();

  fetch_stage #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.imem_q = rom[bus.imem_addr];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural state updated from the block's rules.
  logic [63:0] m_pc;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [63:0] m_ifpc;
  logic        m_halted;
  logic [31:0] m_cnt;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc = 0; m_valid = 0; m_instr = 0; m_ifpc = 0; m_halted = 0; m_cnt = 0;
    end else if (bus.pc_src) begin
      m_pc = bus.pc_branch;
      m_valid = 0;
      m_halted = 0;
    end else if (!m_halted && !bus.stall) begin
      logic [31:0] w;
      w = rom[(m_pc / 4) % 64];
      if (w == 0) begin
        m_halted = 1;
        m_valid = 0;
      end else begin
        m_instr = w;
        m_ifpc = m_pc;
        m_valid = 1;
        m_pc = m_pc + 4;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("imem_addr", 64'(bus.imem_addr), 64'((m_pc / 4) % 64));
    chk("if_valid", 64'(bus.if_valid), 64'(m_valid));
    chk("if_instr", 64'(bus.if_instr), 64'(m_instr));
    chk("if_pc", bus.if_pc, m_ifpc);
    chk("halted", 64'(bus.halted), 64'(m_halted));
    chk("fetch_count", 64'(bus.fetch_count), 64'(m_cnt));
  end

  initial begin
    logic [63:0] exp_pc;
    reset = 1'b1;
    bus.pc_src = 1'b0;
    bus.pc_branch = '0;
    bus.stall = 1'b0;
    for (int i = 0; i < 64; i++) rom[i] = 32'h0;
    for (int i = 0; i < 19; i++) rom[i] = 32'hf800_0000 + 32'(i) * 32'h8000 + 32'(i);
    rom[15] = 32'hb400_004e;
    rom[18] = 32'hf803_800f;

    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(bus.if_valid), 64'd0);
    chk("rst_addr", 64'(bus.imem_addr), 64'd0);
    chk("rst_cnt", 64'(bus.fetch_count), 64'd0);
    chk("rst_halted", 64'(bus.halted), 64'd0);
    reset = 1'b0;

    // first fetch
    @(negedge clk);
    chk("first_valid", 64'(bus.if_valid), 64'd1);
    chk("first_instr", 64'(bus.if_instr), 64'hf800_0000);
    chk("first_pc", bus.if_pc, 64'd0);
    chk("first_addr", 64'(bus.imem_addr), 64'd1);

    // stall at if_pc = 8
    repeat (2) @(negedge clk);
    chk("stall_at_pc", bus.if_pc, 64'h8);
    bus.stall = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_instr", 64'(bus.if_instr), 64'hf801_0002);
      chk("stall_addr", 64'(bus.imem_addr), 64'd3);
    end
    bus.stall = 1'b0;
    @(negedge clk);
    chk("unstall_instr", 64'(bus.if_instr), 64'hf801_8003);

    // run to halt, bounded
    exp_pc = 64'h10;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.halted) break;
      chk("run_if_pc", bus.if_pc, exp_pc);
      exp_pc += 4;
    end
    chk("halt_reached", 64'(bus.halted), 64'd1);
    chk("halt_words", exp_pc, 64'h4c);
    chk("halt_valid", 64'(bus.if_valid), 64'd0);
    chk("halt_addr", 64'(bus.imem_addr), 64'd19);
    chk("halt_cnt", 64'(bus.fetch_count), 64'd19);
    bus.stall = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("halt_cnt_hold", 64'(bus.fetch_count), 64'd19);
    end
    bus.stall = 1'b0;

    // redirect out of HALT
    bus.pc_src = 1'b1;
    bus.pc_branch = 64'h0;
    @(negedge clk);
    chk("unhalt_halted", 64'(bus.halted), 64'd0);
    chk("unhalt_valid", 64'(bus.if_valid), 64'd0);
    bus.pc_src = 1'b0;
    @(negedge clk);
    chk("unhalt_instr", 64'(bus.if_instr), 64'hf800_0000);
    chk("unhalt_cnt", 64'(bus.fetch_count), 64'd20);

    // redirect wins over stall
    repeat (4) @(negedge clk);
    chk("redir_at_pc", bus.if_pc, 64'h10);
    bus.pc_src = 1'b1;
    bus.pc_branch = 64'h3c;
    bus.stall = 1'b1;
    @(negedge clk);
    chk("redir_valid", 64'(bus.if_valid), 64'd0);
    chk("redir_addr", 64'(bus.imem_addr), 64'd15);
    bus.pc_src = 1'b0;
    bus.stall = 1'b0;
    @(negedge clk);
    chk("redir_instr", 64'(bus.if_instr), 64'hb400_004e);
    chk("redir_pc", bus.if_pc, 64'h3c);
    chk("redir_valid2", 64'(bus.if_valid), 64'd1);

    // asynchronous reset between edges
    bus.pc_src = 1'b1;
    bus.pc_branch = 64'h20;
    @(negedge clk);
    bus.pc_src = 1'b0;
    @(negedge clk);
    chk("arst_at_pc", bus.if_pc, 64'h20);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", 64'(bus.if_valid), 64'd0);
    chk("arst_instr", 64'(bus.if_instr), 64'd0);
    chk("arst_pc", bus.if_pc, 64'd0);
    chk("arst_addr", 64'(bus.imem_addr), 64'd0);
    chk("arst_cnt", 64'(bus.fetch_count), 64'd0);
    chk("arst_halted", 64'(bus.halted), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // randomized phase
    for (int i = 0; i < 64; i++)
      rom[i] = ($urandom_range(0, 5) == 0) ? 32'h0 : ($urandom | 32'h1);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      bus.pc_src = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0)
        bus.pc_branch = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
      else
        bus.pc_branch = {$urandom, $urandom};
      bus.stall = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 19) == 0)
        rom[$urandom_range(0, 63)] = ($urandom_range(0, 2) == 0) ? 32'h0 : ($urandom | 32'h1);
    end
    reset = 1'b0;
    bus.pc_src = 1'b0;
    bus.stall = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage for the LEGv8 single-cycle/pipelined processor. It owns the program counter and drives the 6-bit word address of the instruction ROM `imem`, which has a combinational read. It captures the returned 32-bit word into an IF/ID register with a valid flag for the decode stage. It also handles decode back-pressure, branch redirects and flushes, an end-of-program halt and a fetch counter.

## Interface
- `N`, default 64: PC and branch-target width in bits.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high reset.
- `imem_addr` out 6: word address to `imem`; always equal to `pc[7:2]`.
- `imem_q` in 32: instruction word from `imem`, valid in the same cycle.
- `pc_src` in 1: branch taken; redirect the PC to `pc_branch`.
- `pc_branch` in N: branch target byte address.
- `stall` in 1: decode not ready; hold the PC and the IF/ID register.
- `if_valid` out 1: the IF/ID register holds a live instruction.
- `if_instr` out 32: registered instruction.
- `if_pc` out N: byte address of `if_instr`.
- `halted` out 1: stage is in HALT.
- `fetch_count` out 32: number of accepted fetches; saturating.

## Operation
- Internal register `pc` [N-1:0] is visible only through `imem_addr`.
- `pc[1:0]` is ignored. `pc[N-1:8]` is kept but does not affect the ROM address, so the ROM aliases every 256 bytes.
- FSM has two states, RUN and HALT. Reset state is RUN.
- Per-edge priority: reset > `pc_src` > `stall` > halt detect > normal fetch.
- **Redirect** (`pc_src`=1, either state):
  - `pc` <= `pc_branch`, `if_valid` <= 0, state <= RUN.
  - `if_instr` and `if_pc` hold.
  - `stall` is ignored.
- **Stall** (RUN, `pc_src`=0, `stall`=1): `pc`, `if_valid`, `if_instr`, `if_pc` and `fetch_count` all hold.
- **Halt detect** (RUN, no redirect, no stall, `imem_q`==32'h0):
  - State <= HALT, `if_valid` <= 0.
  - `pc` holds, pointing at the zero word.
  - `fetch_count` holds.
  - 32'h0 is the end-of-program sentinel; the ROM is zero-filled past the program.
- **Normal fetch** (RUN, no redirect, no stall, `imem_q`!=0):
  - `if_instr` <= `imem_q`, `if_pc` <= `pc`, `if_valid` <= 1.
  - `pc` <= `pc` + 4, modulo 2^N.
  - `fetch_count` <= `fetch_count` + 1, saturating at 32'hFFFFFFFF.
- **HALT** without `pc_src`: all registers hold, `if_valid` stays 0, `stall` is irrelevant.
- `halted` = (state == HALT), decoded directly from the state register.

## Timing
- Reset (asynchronous, takes effect immediately):
  - `pc`=0, `imem_addr`=0, `if_valid`=0, `if_instr`=32'h0, `if_pc`=0, `halted`=0, `fetch_count`=0, state RUN.
- `imem_addr` is combinational from `pc`, so there is no extra ROM latency.
- Fetch latency: the word at `pc` appears on `if_instr` with `if_valid`=1 one edge after `pc` holds that value.
- First valid instruction appears after the first rising edge following reset deassertion.
- Throughput: one instruction per cycle when `stall`=0.
- Redirect latency:
  - The edge that samples `pc_src`=1 loads the target and drops `if_valid` for exactly one cycle.
  - The next edge delivers the target instruction.
- Entering HALT: `halted` rises on the edge where the sentinel is seen, with `if_valid` low in the same cycle.
- Reset asserted mid-stall or mid-HALT: all state is cleared immediately. Fetch restarts at 0 after release.

## Test plan
- **Reset and first fetch:** load ROM words 0..18 = f8000000, f8008001, …, f803800f, rest zero; release reset; one edge -> `if_valid`=1, `if_instr`=32'hf8000000, `if_pc`=0, `imem_addr`=1.
- **Run to halt:** free-run with `stall`=0, `pc_src`=0.
  - Expect 19 consecutive valid words with `if_pc` = 0, 4, …, 0x48.
  - The next edge gives `halted`=1, `if_valid`=0, `imem_addr`=19, `fetch_count`=19.
  - `fetch_count` stays 19 for the following 10 edges.
- **Stall hold:** assert `stall` for 3 cycles while `if_pc`=0x8.
  - `if_instr`=32'hf8010002 and `imem_addr`=3 stay unchanged.
  - Releasing `stall` delivers 32'hf8018003 on the next edge.
- **Redirect priority:** at `if_pc`=0x10, assert `pc_src`=1, `pc_branch`=0x3C, `stall`=1 together.
  - Next edge: `if_valid`=0, `imem_addr`=15.
  - Following edge (`pc_src`=0, `stall`=0): `if_instr`=32'hb400004e, `if_pc`=0x3C.
- **Redirect out of HALT:** while `halted`=1, pulse `pc_src` with `pc_branch`=0.
  - `halted`=0 on that edge.
  - Next edge: `if_instr`=32'hf8000000, `fetch_count`=20.
- **Asynchronous reset mid-run:** assert `reset` between edges at `if_pc`=0x20 -> all outputs drop to their reset values without waiting for a clock edge.
